// File: rtl/hyper_mvblck_pkg.sv
// Shared types and widths for the LSAB->DRAM block mover.
package hyper_mvblck_pkg;

  localparam int SEC_W = 2;
  localparam int COL_W = 12;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/hyper_mvblck_todram_skid2.sv
// Two-entry FIFO holding popped LSAB words (data + interrupt marker) while the MCU stalls.
module hyper_skid2 #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push_i,
  input  logic [DW-1:0] pushData_i,
  input  logic          pushInt_i,
  input  logic          pop_i,
  output logic [DW-1:0] headData_o,
  output logic          headInt_o,
  output logic [1:0]    occupancy_o
);

  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
  logic          int0_q, int0_d, int1_q, int1_d;
  logic [1:0]    occ_q, occ_d;

  // Pop shifts entry 1 forward first, so a same-cycle push lands behind the survivor.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    int0_d  = int0_q;
    int1_d  = int1_q;
    occ_d   = occ_q;
    if (pop_i && occ_q != 2'd0) begin
      data0_d = data1_q;
      int0_d  = int1_q;
      occ_d   = occ_q - 2'd1;
    end
    if (push_i && occ_d != 2'd2) begin
      if (occ_d == 2'd0) begin
        data0_d = pushData_i;
        int0_d  = pushInt_i;
      end else begin
        data1_d = pushData_i;
        int1_d  = pushInt_i;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      data0_q <= '0;
      data1_q <= '0;
      int0_q  <= 1'b0;
      int1_q  <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      int0_q  <= int0_d;
      int1_q  <= int1_d;
      occ_q   <= occ_d;
    end
  end

  assign headData_o  = data0_q;
  assign headInt_o   = int0_q;
  assign occupancy_o = occ_q;

endmodule

// File: rtl/hyper_mvblck_todram.sv
// Block mover: drains one LSAB section into the MCU write port per issued command.
module hyper_mvblck_todram
  import hyper_mvblck_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [COL_W-1:0] BLCK_START,
  input  logic [CNT_W-1:0] BLCK_COUNT_REQ,
  input  logic             BLCK_ISSUE,
  input  logic [SEC_W-1:0] BLCK_SECTION,
  output logic [CNT_W-1:0] BLCK_COUNT_SENT,
  output logic             BLCK_WORKING,
  output logic             BLCK_IRQ,
  output logic             BLCK_ABRUPT_STOP,
  output logic             LSAB_READ,
  output logic [SEC_W-1:0] LSAB_SECTION,
  input  logic [DW-1:0]    LSAB_DATA,
  input  logic             LSAB_INT,
  input  logic [3:0]       LSAB_EMPTY,
  output logic             MCU_WE,
  output logic [COL_W-1:0] MCU_COL_ADDR,
  output logic [DW-1:0]    MCU_WDATA,
  input  logic             MCU_STALL
);

  state_t           state_q, state_d;
  logic [COL_W-1:0] startCol_q, startCol_d;
  logic [CNT_W-1:0] reqCnt_q, reqCnt_d, issued_q, issued_d, sent_q, sent_d;
  logic [SEC_W-1:0] section_q, section_d;
  logic             inFlight_q, inFlight_d, stopPend_q, stopPend_d;
  logic             irqHit_q, irqHit_d, abruptHit_q, abruptHit_d;
  logic             irqOut_q, irqOut_d, abruptOut_q, abruptOut_d;
  logic             working_q, working_d;

  logic [1:0]    skidOcc;
  logic [DW-1:0] skidData, wordData;
  logic          skidInt, skidPush, skidPop, skidBusy;
  logic          wordValid, wordInt, arrivalInt, retire, popReq, secEmpty, haveCredit;

  // An arriving word bypasses the skid when it is empty, giving the one-cycle pop-to-write path.
  assign skidBusy   = (skidOcc != 2'd0);
  assign secEmpty   = LSAB_EMPTY[section_q];
  assign arrivalInt = inFlight_q & LSAB_INT;
  assign wordValid  = skidBusy | inFlight_q;
  assign wordData   = skidBusy ? skidData : (inFlight_q ? LSAB_DATA : '0);
  assign wordInt    = skidBusy ? skidInt : arrivalInt;
  assign retire     = wordValid & ~MCU_STALL;
  assign skidPush   = inFlight_q & (skidBusy | MCU_STALL);
  assign skidPop    = skidBusy & ~MCU_STALL;
  assign haveCredit = (skidOcc + {1'b0, inFlight_q}) < 2'd2;
  assign popReq     = (state_q == STREAM) & (issued_q < reqCnt_q) & ~secEmpty
                    & ~stopPend_q & ~arrivalInt & haveCredit;

  hyper_skid2 #(.DW(DW)) u_skid (
    .CLK         (CLK),
    .RST         (RST),
    .push_i      (skidPush),
    .pushData_i  (LSAB_DATA),
    .pushInt_i   (LSAB_INT),
    .pop_i       (skidPop),
    .headData_o  (skidData),
    .headInt_o   (skidInt),
    .occupancy_o (skidOcc)
  );

  always_comb begin
    state_d     = state_q;
    startCol_d  = startCol_q;
    reqCnt_d    = reqCnt_q;
    section_d   = section_q;
    issued_d    = issued_q;
    sent_d      = sent_q;
    stopPend_d  = stopPend_q;
    irqHit_d    = irqHit_q;
    abruptHit_d = abruptHit_q;
    irqOut_d    = irqOut_q;
    abruptOut_d = abruptOut_q;
    working_d   = working_q;
    inFlight_d  = popReq;
    if (popReq) issued_d = issued_q + CNT_W'(1);
    if (retire) begin
      sent_d = sent_q + CNT_W'(1);
      if (wordInt) irqHit_d = 1'b1;
    end
    if (arrivalInt) stopPend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (BLCK_ISSUE) begin
          startCol_d  = BLCK_START;
          reqCnt_d    = BLCK_COUNT_REQ;
          section_d   = BLCK_SECTION;
          issued_d    = '0;
          sent_d      = '0;
          stopPend_d  = 1'b0;
          irqHit_d    = 1'b0;
          abruptHit_d = 1'b0;
          irqOut_d    = 1'b0;
          abruptOut_d = 1'b0;
          working_d   = 1'b1;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        // Section ran dry with nothing left to write: end the block short.
        if (issued_q < reqCnt_q && secEmpty && !inFlight_q && !skidBusy && !stopPend_q) begin
          stopPend_d  = 1'b1;
          abruptHit_d = 1'b1;
        end
        if (issued_q == reqCnt_q || stopPend_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (!skidBusy && !inFlight_q) begin
          state_d     = IDLE;
          working_d   = 1'b0;
          irqOut_d    = irqHit_q;
          abruptOut_d = abruptHit_q | irqHit_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      startCol_q  <= '0;
      reqCnt_q    <= '0;
      section_q   <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      inFlight_q  <= 1'b0;
      stopPend_q  <= 1'b0;
      irqHit_q    <= 1'b0;
      abruptHit_q <= 1'b0;
      irqOut_q    <= 1'b0;
      abruptOut_q <= 1'b0;
      working_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      startCol_q  <= startCol_d;
      reqCnt_q    <= reqCnt_d;
      section_q   <= section_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      inFlight_q  <= inFlight_d;
      stopPend_q  <= stopPend_d;
      irqHit_q    <= irqHit_d;
      abruptHit_q <= abruptHit_d;
      irqOut_q    <= irqOut_d;
      abruptOut_q <= abruptOut_d;
      working_q   <= working_d;
    end
  end

  assign BLCK_COUNT_SENT  = sent_q;
  assign BLCK_WORKING     = working_q;
  assign BLCK_IRQ         = irqOut_q;
  assign BLCK_ABRUPT_STOP = abruptOut_q;
  assign LSAB_READ        = popReq;
  assign LSAB_SECTION     = section_q;
  assign MCU_WE           = wordValid;
  assign MCU_COL_ADDR     = startCol_q + COL_W'(sent_q);
  assign MCU_WDATA        = wordData;

endmodule

// File: tb/tb_hyper_mvblck_todram.sv
// Directed bench for hyper_mvblck_todram with a behavioural LSAB section and MCU stall source.
module tb_hyper_mvblck_todram;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [11:0] BLCK_START = '0;
  logic [5:0]  BLCK_COUNT_REQ = '0;
  logic        BLCK_ISSUE = 1'b0;
  logic [1:0]  BLCK_SECTION = '0;
  logic [5:0]  BLCK_COUNT_SENT;
  logic        BLCK_WORKING, BLCK_IRQ, BLCK_ABRUPT_STOP, LSAB_READ, MCU_WE;
  logic [1:0]  LSAB_SECTION;
  logic [31:0] LSAB_DATA = '0;
  logic        LSAB_INT = 1'b0;
  logic [3:0]  LSAB_EMPTY = 4'hF;
  logic [11:0] MCU_COL_ADDR;
  logic [31:0] MCU_WDATA;
  logic        MCU_STALL = 1'b0;

  hyper_mvblck_todram #(.DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .BLCK_START(BLCK_START), .BLCK_COUNT_REQ(BLCK_COUNT_REQ), .BLCK_ISSUE(BLCK_ISSUE),
    .BLCK_SECTION(BLCK_SECTION), .BLCK_COUNT_SENT(BLCK_COUNT_SENT), .BLCK_WORKING(BLCK_WORKING),
    .BLCK_IRQ(BLCK_IRQ), .BLCK_ABRUPT_STOP(BLCK_ABRUPT_STOP), .LSAB_READ(LSAB_READ),
    .LSAB_SECTION(LSAB_SECTION), .LSAB_DATA(LSAB_DATA), .LSAB_INT(LSAB_INT),
    .LSAB_EMPTY(LSAB_EMPTY), .MCU_WE(MCU_WE), .MCU_COL_ADDR(MCU_COL_ADDR),
    .MCU_WDATA(MCU_WDATA), .MCU_STALL(MCU_STALL)
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] qData[$];
  bit          qInt[$];
  logic [1:0]  activeSec = 2'd0;
  logic [11:0] wrCol[$];
  logic [31:0] wrData[$];
  bit          stallEn = 0;
  bit          prevStalled = 0;
  logic [11:0] prevCol = '0;
  logic [31:0] prevData = '0;
  int holdErr = 0, secErr = 0, popErr = 0;
  int cyc = 0, issueCyc = 0, firstWe = -1, workCycles = 0;
  bit timedOut = 0;
  logic       sWorking, sIrq, sAbrupt;
  logic [5:0] sSent;

  task automatic updEmpty();
    LSAB_EMPTY = 4'hF;
    LSAB_EMPTY[activeSec] = (qData.size() == 0);
  endtask

  task automatic loadSection(input logic [1:0] sec, input int n, input logic [31:0] base, input int intIdx);
    qData.delete();
    qInt.delete();
    activeSec = sec;
    for (int i = 0; i < n; i++) begin
      qData.push_back(base + 32'(i));
      qInt.push_back(i == intIdx);
    end
    updEmpty();
  endtask

  // Samples outputs at the negedge, then models one LSAB/MCU cycle across the next posedge.
  task automatic stepCycle();
    bit rd;
    cyc++;
    sWorking = BLCK_WORKING;
    sIrq     = BLCK_IRQ;
    sAbrupt  = BLCK_ABRUPT_STOP;
    sSent    = BLCK_COUNT_SENT;
    if (BLCK_WORKING) workCycles++;
    if (prevStalled && (!MCU_WE || MCU_COL_ADDR !== prevCol || MCU_WDATA !== prevData)) holdErr++;
    if (MCU_WE && firstWe < 0) firstWe = cyc;
    if (MCU_WE && !MCU_STALL) begin
      wrCol.push_back(MCU_COL_ADDR);
      wrData.push_back(MCU_WDATA);
    end
    prevStalled = MCU_WE && MCU_STALL;
    prevCol     = MCU_COL_ADDR;
    prevData    = MCU_WDATA;
    if (LSAB_READ && LSAB_SECTION !== activeSec) secErr++;
    rd = LSAB_READ;
    @(posedge CLK);
    #1;
    BLCK_ISSUE = 1'b0;
    if (rd && qData.size() > 0) begin
      LSAB_DATA = qData.pop_front();
      LSAB_INT  = qInt.pop_front();
    end else begin
      if (rd) popErr++;
      LSAB_DATA = '0;
      LSAB_INT  = 1'b0;
    end
    updEmpty();
    MCU_STALL = stallEn ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge CLK);
  endtask

  task automatic runBlock(input logic [11:0] start, input logic [5:0] cnt, input logic [1:0] sec, input int injectAt);
    wrCol.delete();
    wrData.delete();
    holdErr = 0; secErr = 0; popErr = 0;
    prevStalled = 0; firstWe = -1; workCycles = 0; timedOut = 1;
    BLCK_START = start;
    BLCK_COUNT_REQ = cnt;
    BLCK_SECTION = sec;
    BLCK_ISSUE = 1'b1;
    stepCycle();
    issueCyc = cyc;
    for (int k = 0; k < 300; k++) begin
      if (k == injectAt) begin
        BLCK_ISSUE = 1'b1;
        BLCK_START = 12'h300;
        BLCK_COUNT_REQ = 6'd2;
        BLCK_SECTION = 2'd3;
      end
      stepCycle();
      if (!sWorking) begin
        timedOut = 0;
        break;
      end
    end
    stallEn = 0;
    MCU_STALL = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    compared++;
    if ({BLCK_WORKING, BLCK_IRQ, BLCK_ABRUPT_STOP, LSAB_READ, MCU_WE} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b want 00000", {BLCK_WORKING, BLCK_IRQ, BLCK_ABRUPT_STOP, LSAB_READ, MCU_WE});
    end
    compared++;
    if ({BLCK_COUNT_SENT, MCU_COL_ADDR, MCU_WDATA, LSAB_SECTION} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: sent=%0d col=%h data=%h sec=%0d want all 0", BLCK_COUNT_SENT, MCU_COL_ADDR, MCU_WDATA, LSAB_SECTION);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    loadSection(2'd2, 12, 32'hA000_0000, -1);
    runBlock(12'h010, 6'd8, 2'd2, -1);
    compared++;
    if (timedOut || wrCol.size() != 8) begin
      mismatched++;
      $display("[TB] FAIL basic_count: timeout=%0d writes=%0d want 0/8", timedOut, wrCol.size());
    end
    for (int k = 0; k < 8 && k < wrCol.size(); k++) begin
      compared++;
      if (wrCol[k] !== 12'h010 + 12'(k) || wrData[k] !== 32'hA000_0000 + 32'(k)) begin
        mismatched++;
        $display("[TB] FAIL basic_word%0d: col=%h data=%h want %h/%h", k, wrCol[k], wrData[k], 12'h010 + 12'(k), 32'hA000_0000 + 32'(k));
      end
    end
    compared++;
    if (sSent !== 6'd8 || sIrq !== 1'b0 || sAbrupt !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_status: sent=%0d irq=%b abrupt=%b want 8/0/0", sSent, sIrq, sAbrupt);
    end
    compared++;
    if (workCycles != 10 || firstWe - issueCyc != 2) begin
      mismatched++;
      $display("[TB] FAIL basic_timing: working=%0d firstWe=+%0d want 10/+2", workCycles, firstWe - issueCyc);
    end
    compared++;
    if (secErr != 0 || qData.size() != 4) begin
      mismatched++;
      $display("[TB] FAIL basic_pops: badSection=%0d left=%0d want 0/4", secErr, qData.size());
    end
  endtask

  task automatic test_empty_stop();
    loadSection(2'd1, 3, 32'hB000_0000, -1);
    runBlock(12'h080, 6'd5, 2'd1, -1);
    compared++;
    if (timedOut || wrCol.size() != 3 || wrData.size() != 3 || wrData[2] !== 32'hB000_0002 || wrCol[2] !== 12'h082) begin
      mismatched++;
      $display("[TB] FAIL empty_writes: timeout=%0d writes=%0d want 0/3 ending B0000002@082", timedOut, wrCol.size());
    end
    compared++;
    if (sSent !== 6'd3 || sIrq !== 1'b0 || sAbrupt !== 1'b1 || popErr != 0) begin
      mismatched++;
      $display("[TB] FAIL empty_status: sent=%0d irq=%b abrupt=%b popErr=%0d want 3/0/1/0", sSent, sIrq, sAbrupt, popErr);
    end
  endtask

  task automatic test_irq_stop();
    loadSection(2'd0, 10, 32'h1234_0000, 3);
    runBlock(12'h100, 6'd10, 2'd0, -1);
    compared++;
    if (timedOut || wrCol.size() != 4 || wrData.size() != 4 || wrData[3] !== 32'h1234_0003 || wrCol[3] !== 12'h103) begin
      mismatched++;
      $display("[TB] FAIL irq_writes: timeout=%0d writes=%0d want 0/4 ending 12340003@103", timedOut, wrCol.size());
    end
    compared++;
    if (sSent !== 6'd4 || sIrq !== 1'b1 || sAbrupt !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL irq_status: sent=%0d irq=%b abrupt=%b want 4/1/1", sSent, sIrq, sAbrupt);
    end
    compared++;
    if (qData.size() != 6) begin
      mismatched++;
      $display("[TB] FAIL irq_no_extra_pop: left=%0d want 6", qData.size());
    end
  endtask

  task automatic test_stall();
    loadSection(2'd3, 8, 32'h5500_0000, -1);
    stallEn = 1;
    MCU_STALL = 1'b1;
    runBlock(12'h3C0, 6'd6, 2'd3, -1);
    compared++;
    if (timedOut || wrCol.size() != 6) begin
      mismatched++;
      $display("[TB] FAIL stall_count: timeout=%0d writes=%0d want 0/6", timedOut, wrCol.size());
    end
    for (int k = 0; k < 6 && k < wrCol.size(); k++) begin
      compared++;
      if (wrCol[k] !== 12'h3C0 + 12'(k) || wrData[k] !== 32'h5500_0000 + 32'(k)) begin
        mismatched++;
        $display("[TB] FAIL stall_word%0d: col=%h data=%h want %h/%h", k, wrCol[k], wrData[k], 12'h3C0 + 12'(k), 32'h5500_0000 + 32'(k));
      end
    end
    compared++;
    if (holdErr != 0 || popErr != 0 || sSent !== 6'd6 || qData.size() != 2) begin
      mismatched++;
      $display("[TB] FAIL stall_integrity: holdErr=%0d popErr=%0d sent=%0d left=%0d want 0/0/6/2", holdErr, popErr, sSent, qData.size());
    end
  endtask

  task automatic test_wrap_and_zero();
    loadSection(2'd1, 4, 32'hC000_0000, -1);
    runBlock(12'hFFE, 6'd4, 2'd1, -1);
    compared++;
    if (timedOut || wrCol.size() != 4 || wrCol[0] !== 12'hFFE || wrCol[1] !== 12'hFFF || wrCol[2] !== 12'h000 || wrCol[3] !== 12'h001) begin
      mismatched++;
      $display("[TB] FAIL wrap_cols: timeout=%0d writes=%0d want FFE,FFF,000,001", timedOut, wrCol.size());
    end
    compared++;
    if (sSent !== 6'd4 || wrData.size() != 4 || wrData[3] !== 32'hC000_0003) begin
      mismatched++;
      $display("[TB] FAIL wrap_sent: sent=%0d want 4", sSent);
    end
    loadSection(2'd2, 4, 32'hD000_0000, -1);
    runBlock(12'h050, 6'd0, 2'd2, -1);
    compared++;
    if (timedOut || wrCol.size() != 0 || qData.size() != 4) begin
      mismatched++;
      $display("[TB] FAIL zero_activity: timeout=%0d writes=%0d left=%0d want 0/0/4", timedOut, wrCol.size(), qData.size());
    end
    compared++;
    if (sSent !== 6'd0 || sIrq !== 1'b0 || sAbrupt !== 1'b0 || workCycles < 1 || workCycles > 2) begin
      mismatched++;
      $display("[TB] FAIL zero_status: sent=%0d irq=%b abrupt=%b working=%0d want 0/0/0/1..2", sSent, sIrq, sAbrupt, workCycles);
    end
  endtask

  task automatic test_issue_while_working();
    loadSection(2'd0, 6, 32'h7700_0000, -1);
    runBlock(12'h200, 6'd4, 2'd0, 1);
    compared++;
    if (timedOut || wrCol.size() != 4 || wrCol[3] !== 12'h203 || wrData[3] !== 32'h7700_0003) begin
      mismatched++;
      $display("[TB] FAIL ignore_issue: timeout=%0d writes=%0d want 0/4 ending 77000003@203", timedOut, wrCol.size());
    end
    compared++;
    if (sSent !== 6'd4 || secErr != 0 || qData.size() != 2) begin
      mismatched++;
      $display("[TB] FAIL ignore_status: sent=%0d badSection=%0d left=%0d want 4/0/2", sSent, secErr, qData.size());
    end
  endtask

  task automatic test_reset_mid_block();
    loadSection(2'd2, 12, 32'hD100_0000, -1);
    wrCol.delete();
    wrData.delete();
    prevStalled = 0;
    BLCK_START = 12'h040;
    BLCK_COUNT_REQ = 6'd10;
    BLCK_SECTION = 2'd2;
    BLCK_ISSUE = 1'b1;
    for (int k = 0; k < 20 && wrCol.size() < 3; k++) stepCycle();
    compared++;
    if (wrCol.size() != 3) begin
      mismatched++;
      $display("[TB] FAIL midrst_progress: writes=%0d want 3", wrCol.size());
    end
    RST = 1'b0;
    stepCycle();
    compared++;
    if ({BLCK_WORKING, BLCK_IRQ, BLCK_ABRUPT_STOP, LSAB_READ, MCU_WE} !== 5'b0 ||
        {BLCK_COUNT_SENT, MCU_COL_ADDR, MCU_WDATA, LSAB_SECTION} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midrst_outputs: work=%b we=%b rd=%b sent=%0d col=%h data=%h want all 0", BLCK_WORKING, MCU_WE, LSAB_READ, BLCK_COUNT_SENT, MCU_COL_ADDR, MCU_WDATA);
    end
    RST = 1'b1;
    @(negedge CLK);
    loadSection(2'd1, 3, 32'hE000_0000, -1);
    runBlock(12'h123, 6'd3, 2'd1, -1);
    compared++;
    if (timedOut || wrCol.size() != 3 || wrCol[0] !== 12'h123 || wrData[0] !== 32'hE000_0000 || wrCol[2] !== 12'h125 || wrData[2] !== 32'hE000_0002) begin
      mismatched++;
      $display("[TB] FAIL midrst_rerun: timeout=%0d writes=%0d want 3 at 123..125", timedOut, wrCol.size());
    end
    compared++;
    if (sSent !== 6'd3 || sIrq !== 1'b0 || sAbrupt !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midrst_status: sent=%0d irq=%b abrupt=%b want 3/0/0", sSent, sIrq, sAbrupt);
    end
  endtask

  initial begin
    $display("[TB] starting hyper_mvblck_todram bench");
    test_reset();
    test_basic();
    test_empty_stop();
    test_irq_stop();
    test_stall();
    test_wrap_and_zero();
    test_issue_while_working();
    test_reset_mid_block();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
